// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multi-cycle MIPS control unit. It is a Moore FSM that
// shares one ALU and one unified memory across cycles. FETCH has one Mealy
// term: irwrite and pcwrite follow mem_ready.
// Each memory wait is bounded by WAIT_LIMIT. If the limit is reached, the FSM
// enters the absorbing TRAP state and sets the sticky bus_err flag.
// An undefined opcode or R-type funct also enters TRAP and sets the sticky
// illegal flag.
// Optional feature: define MIPS_MC_JAL_EN to build the jal/jr states.
// Without it, jal and jr decode as illegal instructions.
module mips_mc_controller #(
  parameter int WAIT_LIMIT = 15,
  parameter int TIMER_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluoperation,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       illegal,
  output logic       bus_err
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(WAIT_LIMIT);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXE, S_RTWB,
    S_ADDIEXE, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
`ifdef MIPS_MC_JAL_EN
    , S_JAL, S_JR
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic               mem_wait;

  // The branch decision (zero & pcwritecond) is made in the datapath PC
  // enable, so the controller never looks at the zero flag itself.
  logic unused_zero;
  assign unused_zero = zero;

  // State, wait counter and sticky flags. Reset returns to FETCH asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state, trap detection and wait-counter update.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_wait  = 1'b0;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        mem_wait = 1'b1;
        if (mem_ready) begin
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if (wait_q == LIMIT) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opc)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            if (func == F_JR) begin
`ifdef MIPS_MC_JAL_EN
              state_d = S_JR;
`else
              state_d   = S_TRAP;
              illegal_d = 1'b1;
`endif
            end else begin
              state_d = S_RTEXE;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEXE;
          OP_J:    state_d = S_JUMP;
`ifdef MIPS_MC_JAL_EN
          OP_JAL:  state_d = S_JAL;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
      S_RTEXE: begin
        case (func)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: state_d = S_RTWB;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_ADDIEXE: state_d = S_ADDIWB;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase

    if (state_d != state_q)
      wait_d = '0;
    else if (mem_wait && !mem_ready)
      wait_d = wait_q + TIMER_W'(1);
    else
      wait_d = wait_q;
  end

  // Datapath controls decoded from the current state. FETCH adds the
  // mem_ready term for irwrite and pcwrite.
  always_comb begin
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    pcwritecond  = 1'b0;
    pcsrc        = 2'b00;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluoperation = 3'b000;
    regdst       = 2'b00;
    memtoreg     = 2'b00;
    regwrite     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread      = 1'b1;
        alusrcb      = 2'b01;
        aluoperation = ALU_ADD;
        irwrite      = mem_ready;
        pcwrite      = mem_ready;
      end
      S_DECODE: begin
        alusrcb      = 2'b11;
        aluoperation = ALU_ADD;
      end
      S_MEMADR, S_ADDIEXE: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        aluoperation = ALU_ADD;
      end
      S_ADDIWB: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        aluoperation = ALU_ADD;
        regwrite     = 1'b1;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTEXE: begin
        alusrca = 1'b1;
        case (func)
          F_ADD:   aluoperation = ALU_ADD;
          F_SUB:   aluoperation = ALU_SUB;
          F_AND:   aluoperation = ALU_AND;
          F_OR:    aluoperation = ALU_OR;
          F_SLT:   aluoperation = ALU_SLT;
          default: aluoperation = 3'b000;
        endcase
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      S_BRANCH: begin
        alusrca      = 1'b1;
        aluoperation = ALU_SUB;
        pcwritecond  = 1'b1;
        pcsrc        = 2'b01;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
`ifdef MIPS_MC_JAL_EN
      S_JAL: begin
        pcwrite  = 1'b1;
        pcsrc    = 2'b10;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
      end
      S_JR: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b11;
      end
`endif
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: one instruction at a time, control
// vector checked every cycle against hand-derived per-state values.
module tb_mips_mc_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc, func;
  logic       zero, mem_ready;
  logic       iord, memread, memwrite, irwrite, pcwrite, pcwritecond;
  logic [1:0] pcsrc, alusrcb, regdst, memtoreg;
  logic       alusrca, regwrite, illegal, bus_err;
  logic [2:0] aluoperation;
  int total = 0;
  int bad   = 0;

  mips_mc_controller #(.WAIT_LIMIT(15), .TIMER_W(4)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcwritecond(pcwritecond), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluoperation(aluoperation), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // {iord,memread,memwrite,irwrite,pcwrite,pcwritecond,pcsrc,alusrca,alusrcb,aluop,regdst,memtoreg,regwrite}
  logic [18:0] ctl;
  assign ctl = {iord, memread, memwrite, irwrite, pcwrite, pcwritecond, pcsrc,
                alusrca, alusrcb, aluoperation, regdst, memtoreg, regwrite};

  localparam logic [18:0] E_FETCH1 = {1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b01,3'b010,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_FETCH0 = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b010,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_MEMRD  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,2'b01,1'b1};
  localparam logic [18:0] E_MEMWR  = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_RTADD  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'b010,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_RTSUB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'b110,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_RTWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b01,2'b00,1'b1};
  localparam logic [18:0] E_BRANCH = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,3'b110,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_JUMP   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_JAL    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,2'b00,3'b000,2'b10,2'b10,1'b1};
  localparam logic [18:0] E_JR     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b11,1'b0,2'b00,3'b000,2'b00,2'b00,1'b0};
  localparam logic [18:0] E_ZERO   = '0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010,
                         JAL = 6'b000011, BADOP = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FJR = 6'b001000,
                         FBAD = 6'b000111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, check the control vector mid-cycle, take the edge.
  task automatic cyc(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic r, input logic z, input logic [18:0] e);
    opc = o; func = f; mem_ready = r; zero = z;
    #1;
    chk(tag, 32'(ctl), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between edges; FETCH outputs appear without a clock.
  task automatic do_reset(input string tag);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk({tag, "_ctl"}, 32'(ctl), 32'(E_FETCH1));
    chk({tag, "_flags"}, 32'({illegal, bus_err}), 32'(2'b00));
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opc = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(E_FETCH0));
    chk("reset_flags", 32'({illegal, bus_err}), 32'(2'b00));
    #1;
    rst = 1'b0;

    // lw, zero-wait: 5 cycles, regwrite only in the last
    cyc("lw_fetch",  LW, 6'd0, 1, 0, E_FETCH1);
    cyc("lw_decode", LW, 6'd0, 1, 0, E_DECODE);
    cyc("lw_memadr", LW, 6'd0, 1, 0, E_MEMADR);
    cyc("lw_memrd",  LW, 6'd0, 1, 0, E_MEMRD);
    cyc("lw_memwb",  LW, 6'd0, 1, 0, E_MEMWB);

    // sw with 3 wait cycles in MEMWR: 7 cycles total
    cyc("sw_fetch",  SW, 6'd0, 1, 0, E_FETCH1);
    cyc("sw_decode", SW, 6'd0, 1, 0, E_DECODE);
    cyc("sw_memadr", SW, 6'd0, 1, 0, E_MEMADR);
    for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", SW, 6'd0, 0, 0, E_MEMWR);
    cyc("sw_memwr_done", SW, 6'd0, 1, 0, E_MEMWR);
    chk("sw_bus_err", 32'(bus_err), 32'(0));

    // R-type add then sub
    cyc("add_fetch",  RT, FADD, 1, 0, E_FETCH1);
    cyc("add_decode", RT, FADD, 1, 0, E_DECODE);
    cyc("add_exe",    RT, FADD, 1, 0, E_RTADD);
    cyc("add_wb",     RT, FADD, 1, 0, E_RTWB);
    cyc("sub_fetch",  RT, FSUB, 1, 0, E_FETCH1);
    cyc("sub_decode", RT, FSUB, 1, 0, E_DECODE);
    cyc("sub_exe",    RT, FSUB, 1, 0, E_RTSUB);
    cyc("sub_wb",     RT, FSUB, 1, 0, E_RTWB);

    // beq with zero=1 and zero=0: identical 3-cycle control sequence
    cyc("beq1_fetch",  BEQ, 6'd0, 1, 1, E_FETCH1);
    cyc("beq1_decode", BEQ, 6'd0, 1, 1, E_DECODE);
    cyc("beq1_branch", BEQ, 6'd0, 1, 1, E_BRANCH);
    cyc("beq0_fetch",  BEQ, 6'd0, 1, 0, E_FETCH1);
    cyc("beq0_decode", BEQ, 6'd0, 1, 0, E_DECODE);
    cyc("beq0_branch", BEQ, 6'd0, 1, 0, E_BRANCH);

    // j
    cyc("j_fetch",  J, 6'd0, 1, 0, E_FETCH1);
    cyc("j_decode", J, 6'd0, 1, 0, E_DECODE);
    cyc("j_jump",   J, 6'd0, 1, 0, E_JUMP);

    // addi: 4 cycles, regwrite in cycle 4 to rt with ALUOut
    cyc("addi_fetch",  ADDI, 6'd0, 1, 0, E_FETCH1);
    cyc("addi_decode", ADDI, 6'd0, 1, 0, E_DECODE);
    cyc("addi_exe",    ADDI, 6'd0, 1, 0, E_MEMADR);
    #1;
    chk("addi_wb", 32'({regwrite, regdst, memtoreg, memwrite}), 32'(6'b100000));
    @(posedge clk); #1;
    cyc("after_addi_fetch", J, 6'd0, 1, 0, E_FETCH1);
    chk("no_illegal_yet", 32'(illegal), 32'(0));
    do_reset("rst_a");

    // jal / jr depend on the build option
    cyc("jal_fetch",  JAL, 6'd0, 1, 0, E_FETCH1);
    cyc("jal_decode", JAL, 6'd0, 1, 0, E_DECODE);
`ifdef MIPS_MC_JAL_EN
    cyc("jal_jal",    JAL, 6'd0, 1, 0, E_JAL);
    cyc("jr_fetch",   RT, FJR, 1, 0, E_FETCH1);
    cyc("jr_decode",  RT, FJR, 1, 0, E_DECODE);
    cyc("jr_jr",      RT, FJR, 1, 0, E_JR);
    chk("jal_jr_illegal", 32'(illegal), 32'(0));
`else
    chk("jal_illegal", 32'(illegal), 32'(1));
    cyc("jal_trap", JAL, 6'd0, 1, 0, E_ZERO);
    do_reset("rst_jal");
    cyc("jr_fetch",  RT, FJR, 1, 0, E_FETCH1);
    cyc("jr_decode", RT, FJR, 1, 0, E_DECODE);
    chk("jr_illegal", 32'(illegal), 32'(1));
    cyc("jr_trap", RT, FJR, 1, 0, E_ZERO);
`endif
    do_reset("rst_b");

    // undefined opcode: DECODE -> TRAP, absorbing, strobes low
    cyc("badop_fetch",  BADOP, 6'd0, 1, 0, E_FETCH1);
    cyc("badop_decode", BADOP, 6'd0, 1, 0, E_DECODE);
    chk("badop_illegal", 32'({illegal, bus_err}), 32'(2'b10));
    for (int i = 0; i < 3; i++) cyc("badop_trap", LW, 6'd0, 1, 0, E_ZERO);
    do_reset("rst_c");

    // undefined funct: RTEXE -> TRAP
    cyc("badfn_fetch",  RT, FBAD, 1, 0, E_FETCH1);
    cyc("badfn_decode", RT, FBAD, 1, 0, E_DECODE);
    chk("badfn_not_yet", 32'(illegal), 32'(0));
    cyc("badfn_exe", RT, FBAD, 1, 0, {E_RTADD[18:7], 3'b000, E_RTADD[3:0]});
    chk("badfn_illegal", 32'(illegal), 32'(1));
    cyc("badfn_trap", RT, FBAD, 1, 0, E_ZERO);
    do_reset("rst_d");

    // FETCH timeout: 16 cycles of mem_ready=0 with WAIT_LIMIT=15
    for (int i = 0; i < 15; i++) cyc("to_wait", LW, 6'd0, 0, 0, E_FETCH0);
    chk("to_bus_err_pre", 32'(bus_err), 32'(0));
    cyc("to_wait_last", LW, 6'd0, 0, 0, E_FETCH0);
    chk("to_bus_err", 32'({illegal, bus_err}), 32'(2'b01));
    for (int i = 0; i < 3; i++) cyc("to_trap", LW, 6'd0, 1, 0, E_ZERO);
    do_reset("rst_e");

    // mem_ready in the limit cycle wins
    for (int i = 0; i < 15; i++) cyc("lim_wait", J, 6'd0, 0, 0, E_FETCH0);
    cyc("lim_ready", J, 6'd0, 1, 0, E_FETCH1);
    cyc("lim_decode", J, 6'd0, 1, 0, E_DECODE);
    cyc("lim_jump", J, 6'd0, 1, 0, E_JUMP);
    chk("lim_bus_err", 32'(bus_err), 32'(0));

    // reset mid-lw: instruction abandoned, no write-back after rst rises
    cyc("ab_fetch",  LW, 6'd0, 1, 0, E_FETCH1);
    cyc("ab_decode", LW, 6'd0, 1, 0, E_DECODE);
    cyc("ab_memadr", LW, 6'd0, 1, 0, E_MEMADR);
    do_reset("rst_mid");
    cyc("ab_refetch", LW, 6'd0, 1, 0, E_FETCH1);
    cyc("ab_redecode", LW, 6'd0, 1, 0, E_DECODE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
